// File: rtl/param_fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing the write port of param_fifo
// between N_REQ producers through one registered output stage tagged with a source id.
module param_fifo_wr_arbiter #(
  parameter int WIDTH      = 64,
  parameter int WRITE_SIZE = 4,
  parameter int N_REQ      = 4,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = $clog2(N_REQ)
) (
  input  logic                                        clk_i,
  input  logic                                        reset_i,
  input  logic [N_REQ-1:0]                            req_valid_i,
  output logic [N_REQ-1:0]                            req_ready_o,
  input  logic [N_REQ-1:0][WRITE_SIZE-1:0][WIDTH-1:0] req_data_i,
  output logic                                        fifo_valid_o,
  input  logic                                        fifo_ready_i,
  output logic [WRITE_SIZE-1:0][WIDTH-1:0]            fifo_data_o,
  output logic [ID_WIDTH-1:0]                         fifo_id_o,
  output logic                                        locked_o
);

  localparam int BCW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                          state_q, state_d;
  logic [ID_WIDTH-1:0]             lastGrant_q, lastGrant_d;
  logic [ID_WIDTH-1:0]             owner_q, owner_d;
  logic [BCW-1:0]                  beatCnt_q, beatCnt_d;
  logic [BCW-1:0]                  beatInc;

  logic [WRITE_SIZE-1:0][WIDTH-1:0] fifoData_q;
  logic [ID_WIDTH-1:0]              fifoId_q;
  logic                             fifoValid_q;

  logic                canLoad;
  logic                drain;
  logic                selFound;
  logic [ID_WIDTH-1:0] selIdx;
  logic                accept;
  logic [ID_WIDTH-1:0] acceptIdx;

  assign canLoad = !fifoValid_q | fifo_ready_i;
  assign drain   = fifoValid_q & fifo_ready_i;
  assign beatInc = beatCnt_q + BCW'(1);

  // First valid requester after the last grant, wrapping around.
  always_comb begin
    int                  cand;
    logic [ID_WIDTH-1:0] candIdx;
    selFound = 1'b0;
    selIdx   = '0;
    cand     = 0;
    candIdx  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = int'(lastGrant_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      candIdx = ID_WIDTH'(cand);
      if (!selFound && req_valid_i[candIdx]) begin
        selFound = 1'b1;
        selIdx   = candIdx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      lastGrant_q <= ID_WIDTH'(N_REQ - 1);
      owner_q     <= '0;
      beatCnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      owner_q     <= owner_d;
      beatCnt_q   <= beatCnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    owner_d     = owner_q;
    beatCnt_d   = beatCnt_q;
    accept      = 1'b0;
    acceptIdx   = owner_q;
    unique case (state_q)
      IDLE: begin
        if (selFound && canLoad) begin
          accept    = 1'b1;
          acceptIdx = selIdx;
          owner_d   = selIdx;
          beatCnt_d = BCW'(1);
          if (MAX_BURST == 1) lastGrant_d = selIdx;
          else                state_d     = LOCKED;
        end
      end
      LOCKED: begin
        // The lock survives backpressure; only a dropped owner valid releases early.
        if (req_valid_i[owner_q]) begin
          if (canLoad) begin
            accept    = 1'b1;
            beatCnt_d = beatInc;
            if (beatInc == BCW'(MAX_BURST)) begin
              state_d     = IDLE;
              lastGrant_d = owner_q;
            end
          end
        end else begin
          state_d     = IDLE;
          lastGrant_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset_i) accept = 1'b0;
  end

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[acceptIdx] = 1'b1;
    locked_o = (state_q == LOCKED);
  end

  // A load and a drain can happen in the same cycle, keeping one beat per clock.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fifoValid_q <= 1'b0;
      fifoData_q  <= '0;
      fifoId_q    <= '0;
    end else if (accept) begin
      fifoValid_q <= 1'b1;
      fifoData_q  <= req_data_i[acceptIdx];
      fifoId_q    <= acceptIdx;
    end else if (drain) begin
      fifoValid_q <= 1'b0;
    end
  end

  assign fifo_valid_o = fifoValid_q;
  assign fifo_data_o  = fifoData_q;
  assign fifo_id_o    = fifoId_q;

endmodule

// File: tb/tb_param_fifo_wr_arbiter.sv
// Scoreboard bench for param_fifo_wr_arbiter: one instance with MAX_BURST=4, one with
// MAX_BURST=1, both checked against a cycle-level arbitration model.
module tb_param_fifo_wr_arbiter;
  localparam int N   = 4;
  localparam int WS  = 4;
  localparam int W   = 64;
  localparam int IDW = 2;
  localparam int DW  = WS * W;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } beat_t;

  logic                          clk;
  logic                          resetS     [2];
  logic [N-1:0]                  reqValid   [2];
  logic [N-1:0]                  reqReady   [2];
  logic [N-1:0][WS-1:0][W-1:0]   reqData    [2];
  logic                          fifoValid  [2];
  logic                          fifoReady  [2];
  logic [WS-1:0][W-1:0]          fifoData   [2];
  logic [IDW-1:0]                fifoId     [2];
  logic                          locked     [2];

  int     total = 0;
  int     bad   = 0;
  beat_t  sbBurst[$];
  beat_t  sbSingle[$];

  bit           mLocked   [2];
  int           mOwner    [2];
  int           mCount    [2];
  int           mLast     [2];
  bit           mOutValid [2];
  logic [N-1:0] acceptedLast [2];

  param_fifo_wr_arbiter #(.WIDTH(W), .WRITE_SIZE(WS), .N_REQ(N), .MAX_BURST(4)) dutBurst (
    .clk_i(clk), .reset_i(resetS[0]), .req_valid_i(reqValid[0]), .req_ready_o(reqReady[0]),
    .req_data_i(reqData[0]), .fifo_valid_o(fifoValid[0]), .fifo_ready_i(fifoReady[0]),
    .fifo_data_o(fifoData[0]), .fifo_id_o(fifoId[0]), .locked_o(locked[0]));

  param_fifo_wr_arbiter #(.WIDTH(W), .WRITE_SIZE(WS), .N_REQ(N), .MAX_BURST(1)) dutSingle (
    .clk_i(clk), .reset_i(resetS[1]), .req_valid_i(reqValid[1]), .req_ready_o(reqReady[1]),
    .req_data_i(reqData[1]), .fifo_valid_o(fifoValid[1]), .fifo_ready_i(fifoReady[1]),
    .fifo_data_o(fifoData[1]), .fifo_id_o(fifoId[1]), .locked_o(locked[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int k, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s dut%0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  task automatic resetModel(input int k);
    mLocked[k]      = 1'b0;
    mOwner[k]       = 0;
    mCount[k]       = 0;
    mLast[k]        = N - 1;
    mOutValid[k]    = 1'b0;
    acceptedLast[k] = '0;
    if (k == 0) sbBurst.delete();
    else        sbSingle.delete();
  endtask

  // Requesters keep an unaccepted beat (valid and data) until it is taken.
  task automatic applyStimulus(input int k, input logic [N-1:0] newValid, input bit rdy,
                               input bit rst);
    logic [N-1:0] pending;
    pending      = reqValid[k] & ~acceptedLast[k];
    resetS[k]    = rst;
    fifoReady[k] = rdy;
    for (int i = 0; i < N; i++) begin
      if (!pending[i]) begin
        reqValid[k][i] = newValid[i];
        if (newValid[i])
          for (int c = 0; c < WS; c++) reqData[k][i][c] = {$urandom, $urandom};
      end
    end
  endtask

  // Reference arbitration: round-robin pick, bursts of up to mb beats, release on drop.
  task automatic modelStep(input int k);
    int           mb;
    int           sel;
    int           c;
    bit           found;
    bit           acc;
    bit           canLoad;
    logic [N-1:0] expReady;
    beat_t        b;
    @(negedge clk);
    mb       = (k == 0) ? 4 : 1;
    expReady = '0;
    acc      = 1'b0;
    sel      = 0;
    found    = 1'b0;
    if (resetS[k]) begin
      check("readyInReset", k, DW'(reqReady[k]), '0);
      resetModel(k);
    end else begin
      check("locked", k, DW'(locked[k]), DW'(mLocked[k]));
      check("fifoValid", k, DW'(fifoValid[k]), DW'(mOutValid[k]));
      canLoad = !mOutValid[k] || fifoReady[k];
      if (!mLocked[k]) begin
        for (int j = 1; j <= N; j++) begin
          c = (mLast[k] + j) % N;
          if (!found && reqValid[k][c]) begin
            found = 1'b1;
            sel   = c;
          end
        end
        if (found && canLoad) begin
          acc = 1'b1;
          if (mb == 1) mLast[k] = sel;
          else begin
            mLocked[k] = 1'b1;
            mOwner[k]  = sel;
            mCount[k]  = 1;
          end
        end
      end else if (reqValid[k][mOwner[k]]) begin
        if (canLoad) begin
          acc = 1'b1;
          sel = mOwner[k];
          mCount[k]++;
          if (mCount[k] == mb) begin
            mLocked[k] = 1'b0;
            mLast[k]   = mOwner[k];
          end
        end
      end else begin
        mLocked[k] = 1'b0;
        mLast[k]   = mOwner[k];
      end
      if (acc) begin
        expReady[sel] = 1'b1;
        b.id   = sel;
        b.data = reqData[k][sel];
        if (k == 0) sbBurst.push_back(b);
        else        sbSingle.push_back(b);
      end
      check("reqReady", k, DW'(reqReady[k]), DW'(expReady));
      if (acc)               mOutValid[k] = 1'b1;
      else if (fifoReady[k]) mOutValid[k] = 1'b0;
    end
    acceptedLast[k] = expReady;
    @(posedge clk);
    #1;
  endtask

  task automatic runCycle(input int k, input logic [N-1:0] newValid, input bit rdy,
                          input bit rst);
    applyStimulus(k, newValid, rdy, rst);
    modelStep(k);
  endtask

  task automatic checkOutput(input int k);
    beat_t b;
    int    depth;
    if (!resetS[k] && fifoValid[k] === 1'b1 && fifoReady[k]) begin
      depth = (k == 0) ? sbBurst.size() : sbSingle.size();
      if (depth == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedBeat dut%0d: got id %0d expected no beat", k, fifoId[k]);
      end else begin
        b = (k == 0) ? sbBurst.pop_front() : sbSingle.pop_front();
        check("fifoId", k, DW'(fifoId[k]), DW'(b.id));
        check("fifoData", k, DW'(fifoData[k]), b.data);
      end
    end
  endtask

  always @(negedge clk) begin
    checkOutput(0);
    checkOutput(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      resetS[k]    = 1'b1;
      reqValid[k]  = '0;
      reqData[k]   = '0;
      fifoReady[k] = 1'b1;
      resetModel(k);
    end
    @(posedge clk);
    #1;

    runCycle(0, 4'b0000, 1'b1, 1'b1);
    runCycle(0, 4'b0000, 1'b1, 1'b1);
    // Single directed beat with a recognisable payload.
    applyStimulus(0, 4'b0001, 1'b1, 1'b0);
    reqData[0][0] = {64'd3, 64'd2, 64'd1, 64'd0};
    modelStep(0);
    for (int i = 0; i < 3; i++) runCycle(0, 4'b0000, 1'b1, 1'b0);

    runCycle(0, 4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) runCycle(0, 4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)  runCycle(0, 4'b0000, 1'b1, 1'b0);

    runCycle(0, 4'b0010, 1'b1, 1'b0);
    runCycle(0, 4'b0010, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) runCycle(0, 4'b1100, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) runCycle(0, 4'b0000, 1'b1, 1'b0);

    runCycle(0, 4'b0001, 1'b1, 1'b0);
    runCycle(0, 4'b0001, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) runCycle(0, 4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) runCycle(0, 4'b0001, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) runCycle(0, 4'b0000, 1'b1, 1'b0);

    // Reset in the middle of a burst with a beat sitting in the output register.
    runCycle(0, 4'b1111, 1'b1, 1'b0);
    runCycle(0, 4'b1111, 1'b1, 1'b0);
    runCycle(0, 4'b1111, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) runCycle(0, 4'b1111, 1'b1, 1'b0);

    for (int i = 0; i < 300; i++)
      runCycle(0, N'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) == 0));
    for (int i = 0; i < 16; i++) runCycle(0, 4'b0000, 1'b1, 1'b0);
    runCycle(0, 4'b0000, 1'b1, 1'b1);

    runCycle(1, 4'b0000, 1'b1, 1'b1);
    runCycle(1, 4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) runCycle(1, 4'b0101, 1'b1, 1'b0);
    for (int i = 0; i < 200; i++)
      runCycle(1, N'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) == 0));
    for (int i = 0; i < 16; i++) runCycle(1, 4'b0000, 1'b1, 1'b0);

    check("leftoverBurst", 0, DW'(sbBurst.size()), '0);
    check("leftoverSingle", 1, DW'(sbSingle.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
